// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader -- boot loader: fills instruction memory from a byte stream and
// holds the core in reset until the image is written.
// Optional: define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int DEPTH = 1024
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     In_Valid,
  input  logic [7:0]               In_Data,
  output logic                     In_Ready,
  input  logic                     Start,
  output logic                     Mem_WE,
  output logic [$clog2(DEPTH)-1:0] Mem_Addr,
  output logic [31:0]              Mem_WData,
  output logic                     Core_En,
  output logic                     Error,
  output logic [15:0]              Words_Loaded
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  localparam logic [2:0] ST_LEN_LO = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHK    = 3'd4;
`else
  localparam logic [2:0] ST_WAIT   = 3'd3;
`endif
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [15:0]       n_q, n_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_buf_q, word_buf_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              core_en_q, core_en_d;
  logic [15:0]       words_q, words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic        accept;
  logic [15:0] n_len;
  logic        in_ready;

  always_comb begin
    in_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
`ifdef IMEM_LOADER_CHECKSUM_EN
               (state_q == ST_CHK) ||
`endif
               (state_q == ST_DATA);
  end

  assign accept = In_Valid && in_ready;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    byte_cnt_d  = byte_cnt_q;
    word_buf_d  = word_buf_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    words_d     = words_q;
    n_len       = {In_Data, n_q[7:0]};
    // Core_En lags DONE by one cycle so the final write settles before fetch.
    core_en_d   = (state_q == ST_DONE) && !Start;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d       = xor_q;
`endif

    if (mem_we_q) begin
      mem_addr_d = mem_addr_q + ADDR_ONE;
      words_d    = words_q + 16'd1;
    end

    case (state_q)
      ST_LEN_LO: begin
        if (accept) begin
          n_d[7:0] = In_Data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          n_d = n_len;
          if ({1'b0, n_len} > DEPTH_W) begin
            state_d = ST_ERROR;
          end else if (n_len == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ In_Data;
`endif
          case (byte_cnt_q)
            2'd0: word_buf_d[7:0]   = In_Data;
            2'd1: word_buf_d[15:8]  = In_Data;
            2'd2: word_buf_d[23:16] = In_Data;
            default: begin
              mem_wdata_d = {In_Data, word_buf_q};
              mem_we_d    = 1'b1;
              // No write can be pending here, so words_q indexes this word.
              if (words_q + 16'd1 == n_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = ST_CHK;
`else
                state_d = ST_WAIT;
`endif
              end
            end
          endcase
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (accept) begin
          state_d = (In_Data == xor_q) ? ST_DONE : ST_ERROR;
        end
      end
`else
      ST_WAIT: begin
        state_d = ST_DONE;
      end
`endif
      ST_DONE, ST_ERROR: begin
        if (Start) begin
          state_d    = ST_LEN_LO;
          n_d        = 16'd0;
          byte_cnt_d = 2'd0;
          mem_addr_d = '0;
          words_d    = 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d      = 8'd0;
`endif
        end
      end
      default: state_d = ST_LEN_LO;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_LEN_LO;
      n_q         <= 16'd0;
      byte_cnt_q  <= 2'd0;
      word_buf_q  <= 24'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      core_en_q   <= 1'b0;
      words_q     <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      byte_cnt_q  <= byte_cnt_d;
      word_buf_q  <= word_buf_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_en_q   <= core_en_d;
      words_q     <= words_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q       <= xor_d;
`endif
    end
  end

  assign In_Ready     = in_ready;
  assign Mem_WE       = mem_we_q;
  assign Mem_Addr     = mem_addr_q;
  assign Mem_WData    = mem_wdata_q;
  assign Core_En      = core_en_q;
  assign Error        = (state_q == ST_ERROR);
  assign Words_Loaded = words_q;

endmodule

`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

- Boot-time controller that fills the instruction memory from a byte stream and gates the core.
- Holds the core in reset, receives a 16-bit word count followed by little-endian instruction words, and writes each assembled word to consecutive word addresses starting at 0.
- Releases the core only after the final write has completed.
- Sits between the host/UART byte interface and the instruction-memory write port; drives the core's run/reset enable.

## Interface
- DEPTH, 1024, instruction memory size in 32-bit words; Mem_Addr width is ADDR_W = $clog2(DEPTH) (localparam).
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- In_Valid  input  1  byte on In_Data is valid.
- In_Data  input  8  stream byte.
- In_Ready  output  1  loader can accept a byte; a byte transfers on a rising edge with In_Valid & In_Ready.
- Start  input  1  single-cycle re-arm request; honoured only in DONE or ERROR.
- Mem_WE  output  1  instruction memory write enable, one cycle per word.
- Mem_Addr  output  ADDR_W  word index of the write.
- Mem_WData  output  32  word to write.
- Core_En  output  1  1 = core runs; 0 = core held in reset (drives the core's active-low reset).
- Error  output  1  load failed; sticky until Start or Rst.
- Words_Loaded  output  16  count of words written in the current load.

## Operation
- States: LEN_LO, LEN_HI, DATA, WAIT, CHK (macro only), DONE, ERROR.
- LEN_LO: accept byte -> N[7:0]; go to LEN_HI.
- LEN_HI: accept byte -> N[15:8].
  - If N > DEPTH -> ERROR.
  - Else if N == 0 -> DONE (CHK with macro).
  - Else -> DATA.
- DATA: bytes are packed little-endian; byte k of a word goes to bits [8k+7:8k]. A 2-bit byte counter wraps 3 -> 0.
- On the edge accepting byte 3:
  - Mem_WData and Mem_Addr are registered; Mem_WE = 1 for the next cycle only.
  - After the write cycle, Mem_Addr and Words_Loaded increment.
- On accepting byte 3 of word N-1: go to WAIT (CHK with macro).
- WAIT: one cycle, carries the final Mem_WE; then DONE.
- DONE: Core_En = 1, In_Ready = 0. Start -> LEN_LO; Core_En = 0 from the next cycle; Words_Loaded, Mem_Addr, byte counter and N cleared.
- ERROR: Error = 1, Core_En = 0, In_Ready = 0. Start -> LEN_LO and clears Error.
- Start in any other state is ignored.
- In_Ready = 1 in LEN_LO, LEN_HI, DATA and CHK; 0 otherwise (decoded from registered state).
- Memory contents are never cleared by the loader.

## Timing
- Reset values:
  - State = LEN_LO, so In_Ready = 1 immediately after reset.
  - Mem_WE = 0, Mem_Addr = 0, Mem_WData = 0, Core_En = 0, Error = 0, Words_Loaded = 0.
- Latency: Mem_WE is high exactly one cycle after the edge accepting byte 3 of each word. Back-to-back words at one byte per cycle give one write every 4 cycles.
- Core_En rises at least one full cycle after the last Mem_WE cycle, so a fetch from word 0 sees the new contents. Without the macro, Core_En rises 2 cycles after the final byte is accepted.
- In_Valid may drop between bytes at any point; no timeout.
- Rst mid-load aborts immediately:
  - a partial word is discarded;
  - words already written remain in memory;
  - Core_En stays 0.
- Start coincident with Rst: Rst wins.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last data byte (or after LEN_HI when N == 0), state CHK accepts one extra byte.
  - The expected value is the XOR of all data bytes; length bytes are excluded. For N == 0 the expected value is 0x00.
  - Match -> DONE; mismatch -> ERROR. Words already written stay in memory.
  - The final Mem_WE occurs during the first CHK cycle, so no WAIT state is used.
- IMEM_LOADER_CHECKSUM_EN undefined: no CHK state and no checksum byte; the final word goes through WAIT to DONE.

## Test plan
- Reset then stream 01 00 93 00 50 00 at one byte per cycle:
  - one Mem_WE with Mem_Addr = 0, Mem_WData = 32'h00500093;
  - Core_En = 1 two cycles after the last byte;
  - Words_Loaded = 1.
- N = 3, three words sent with In_Valid toggling every cycle -> writes to addresses 0, 1, 2 in order, each Mem_WE exactly one cycle wide; In_Ready = 0 in DONE.
- Length bytes 01 04 (N = 1025 > 1024) -> Error = 1, Core_En = 0, In_Ready = 0, no Mem_WE. A Start pulse then gives In_Ready = 1 and Error = 0.
- Length bytes 00 00 -> DONE with no writes.
  - Macro off: Core_En = 1.
  - Macro on: byte 00 is required first.
- Rst asserted after 2 data bytes of word 1 -> all outputs return to reset values asynchronously. A fresh load of 1 word writes address 0.
- With IMEM_LOADER_CHECKSUM_EN, word 32'h00A00113 and checksum:
  - 0xB2 -> DONE;
  - 0xB3 -> ERROR, while the word is still written at address 0.
